// File: rtl/sr_cmd_gen_311.sv
// sr_cmd_gen_311: command stage in front of an SR flip-flop.
// Each raw button (set, reset) is synchronised, debounced and rising-edge
// detected into a pending flag; a small FSM serialises pending requests into
// mutually exclusive, registered s_311/r_311 pulses separated by a gap.
// Optional feature: define SR_CMD_CNT_EN to build saturating issued-command
// counters; without it set_cnt_311/rst_cnt_311 are tied to zero.
module sr_cmd_gen_311 #(
    parameter int DEB_CYCLES = 16,
    parameter int PULSE_W    = 1,
    parameter int GAP_CYCLES = 2,
    parameter int PRIO_RESET = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       set_btn_311,
    input  logic       rst_btn_311,
    output logic       s_311,
    output logic       r_311,
    output logic       busy_311,
    output logic       last_cmd_311,
    output logic [7:0] set_cnt_311,
    output logic [7:0] rst_cnt_311
);

    localparam int DEB_W  = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam int TMR_MX = (PULSE_W > GAP_CYCLES) ? PULSE_W : GAP_CYCLES;
    localparam int TMR_W  = $clog2(TMR_MX + 1);

    typedef enum logic [1:0] {IDLE, PULSE_S, PULSE_R, GAP} state_t;

    state_t             state_reg;
    logic [TMR_W-1:0]   tmr_reg;
    logic               s_reg;
    logic               r_reg;
    logic               last_cmd_reg;

    // Channel 0 = set, channel 1 = reset.
    logic [1:0] btn;
    logic [1:0] pend_vec;
    logic [1:0] take;
    logic       take_s;
    logic       take_r;

    assign btn  = {rst_btn_311, set_btn_311};
    assign take = {take_r, take_s};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic             sync1_reg;
            logic             sync2_reg;
            logic             stable_reg;
            logic             stable_d_reg;
            logic             pend_reg;
            logic [DEB_W-1:0] deb_cnt_reg;

            // Synchronise, debounce, detect rising edge and hold the request until served.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sync1_reg    <= 1'b0;
                    sync2_reg    <= 1'b0;
                    stable_reg   <= 1'b0;
                    stable_d_reg <= 1'b0;
                    pend_reg     <= 1'b0;
                    deb_cnt_reg  <= '0;
                end else begin
                    sync1_reg    <= btn[gi];
                    sync2_reg    <= sync1_reg;
                    stable_d_reg <= stable_reg;
                    if (sync2_reg == stable_reg) begin
                        deb_cnt_reg <= '0;
                    end else if (deb_cnt_reg == DEB_W'(DEB_CYCLES - 1)) begin
                        stable_reg  <= sync2_reg;
                        deb_cnt_reg <= '0;
                    end else begin
                        deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
                    end
                    // A fresh edge outranks the clear so a request landing on the
                    // serve cycle is not lost; an edge while pending just merges.
                    if (stable_reg && !stable_d_reg) begin
                        pend_reg <= 1'b1;
                    end else if (take[gi]) begin
                        pend_reg <= 1'b0;
                    end
                end
            end

            assign pend_vec[gi] = pend_reg;
        end
    endgenerate

    // Arbitrate pending requests; only IDLE may start a new pulse.
    always_comb begin
        take_s = 1'b0;
        take_r = 1'b0;
        if (state_reg == IDLE) begin
            if (pend_vec[1] && ((PRIO_RESET != 0) || !pend_vec[0])) begin
                take_r = 1'b1;
            end else if (pend_vec[0]) begin
                take_s = 1'b1;
            end
        end
    end

    // Command serialiser: IDLE -> PULSE_x (PULSE_W cycles) -> GAP (GAP_CYCLES) -> IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            tmr_reg      <= '0;
            s_reg        <= 1'b0;
            r_reg        <= 1'b0;
            last_cmd_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    tmr_reg <= '0;
                    if (take_r) begin
                        state_reg    <= PULSE_R;
                        r_reg        <= 1'b1;
                        last_cmd_reg <= 1'b0;
                    end else if (take_s) begin
                        state_reg    <= PULSE_S;
                        s_reg        <= 1'b1;
                        last_cmd_reg <= 1'b1;
                    end
                end
                PULSE_S, PULSE_R: begin
                    if (tmr_reg == TMR_W'(PULSE_W - 1)) begin
                        state_reg <= GAP;
                        tmr_reg   <= '0;
                        s_reg     <= 1'b0;
                        r_reg     <= 1'b0;
                    end else begin
                        tmr_reg <= tmr_reg + TMR_W'(1);
                    end
                end
                GAP: begin
                    if (tmr_reg == TMR_W'(GAP_CYCLES - 1)) begin
                        state_reg <= IDLE;
                        tmr_reg   <= '0;
                    end else begin
                        tmr_reg <= tmr_reg + TMR_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    tmr_reg   <= '0;
                    s_reg     <= 1'b0;
                    r_reg     <= 1'b0;
                end
            endcase
        end
    end

    assign s_311        = s_reg;
    assign r_311        = r_reg;
    assign last_cmd_311 = last_cmd_reg;
    assign busy_311     = (state_reg != IDLE) || (|pend_vec);

`ifdef SR_CMD_CNT_EN
    logic [7:0] set_cnt_reg;
    logic [7:0] rst_cnt_reg;

    // Saturating counts of issued commands, counted on PULSE entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            set_cnt_reg <= 8'h00;
            rst_cnt_reg <= 8'h00;
        end else begin
            if (take_s && (set_cnt_reg != 8'hFF)) begin
                set_cnt_reg <= set_cnt_reg + 8'h01;
            end
            if (take_r && (rst_cnt_reg != 8'hFF)) begin
                rst_cnt_reg <= rst_cnt_reg + 8'h01;
            end
        end
    end

    assign set_cnt_311 = set_cnt_reg;
    assign rst_cnt_311 = rst_cnt_reg;
`else
    assign set_cnt_311 = 8'h00;
    assign rst_cnt_311 = 8'h00;
`endif

endmodule
